pll_reconf_seq: RTL and testbench
=================================

PLL_RECONF_SEQ -- requirements
Module: pll_reconf_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 16: entry FIFO depth, power of two, 4..64.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 64: cycles to wait after the start write before sampling lock.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000: lock watchdog limit.
REQ-004 SHALL have ports `clk  in  1  sole clock` and `rst_n  in  1  asynchronous active-low reset`.
REQ-005 SHALL have ports `wr_en  in  1  push entry`, `wr_addr  in  6  PLL reconfig register`, `wr_data  in  32  register value`.
REQ-006 SHALL have ports `cfg_start  in  1  launch sequence`, `busy  out  1`, `done  out  1  one-cycle success pulse`, `err  out  1  one-cycle failure pulse`, `ovf  out  1  sticky push-while-full flag`.
REQ-007 SHALL have ports `mgmt_address  out  6`, `mgmt_writedata  out  32`, `mgmt_write  out  1`, `mgmt_waitrequest  in  1`, `pll_locked  in  1`.

Function
REQ-008 States SHALL be IDLE, MODE, STREAM, START, SETTLE, WAIT_LOCK, DONE, ERR.
REQ-009 An Avalon write SHALL hold address, data and mgmt_write stable until a cycle with mgmt_waitrequest=0, which is the accept cycle.
REQ-010 wr_en in IDLE with the FIFO not full SHALL push {wr_addr, wr_data}; wr_en when full SHALL drop the entry and set ovf; wr_en when busy=1 SHALL be ignored.
REQ-011 cfg_start in IDLE with a non-empty FIFO SHALL enter MODE the next cycle with mgmt_address=0, mgmt_writedata=0 and mgmt_write=1 (waitrequest mode).
REQ-012 cfg_start with an empty FIFO, or while busy=1, SHALL be ignored.
REQ-013 wr_en and cfg_start in the same IDLE cycle SHALL push the entry and include it in the sequence.
REQ-014 MODE accept → STREAM: each entry is popped on its accept, in FIFO order, with no idle cycle between the accept and the next write.
REQ-015 After the last entry is accepted the block SHALL go to START and write address 2, data 1.
REQ-016 START accept → SETTLE: count SETTLE_CYCLES cycles, then enter WAIT_LOCK.
REQ-017 WAIT_LOCK with pll_locked=1 → DONE: done=1 for one cycle, then IDLE.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 mgmt_write SHALL be 0 in IDLE, SETTLE, WAIT_LOCK, DONE and ERR.
REQ-020 ERR SHALL pulse err for one cycle, then go to IDLE.
REQ-021 FIFO pointers SHALL be log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH; full and empty are decided by comparing the MSBs.
REQ-022 ovf SHALL clear only on reset or on cfg_start acceptance.

Reset
REQ-023 On rst_n=0 (asynchronous), the block SHALL go to IDLE, empty the FIFO and clear all counters.
REQ-024 Reset values: mgmt_write=0, mgmt_address=0, mgmt_writedata=0, busy=0, done=0, err=0, ovf=0.
REQ-025 A reset mid-sequence SHALL drop mgmt_write immediately and discard the remaining entries.
REQ-026 Reset release SHALL be synchronized inside the block with a 2-flop deassertion synchronizer.

Configuration
REQ-027 With PLL_RECONF_TIMEOUT_EN defined, a watchdog SHALL count cycles spent in WAIT_LOCK and enter ERR when the count reaches TIMEOUT_CYCLES; the counter restarts on each WAIT_LOCK entry.
REQ-028 Without PLL_RECONF_TIMEOUT_EN, WAIT_LOCK SHALL wait indefinitely, err SHALL be tied to 0, and no watchdog logic exists.

Structure
REQ-029 Package pll_reconf_pkg SHALL hold the state enum, REG_MODE=6'd0, REG_START=6'd2 and the 38-bit entry typedef.
REQ-030 The FIFO SHALL be sub-module pll_reconf_fifo (push, pop, full, empty, head); the FSM and counters stay in the top module.

Verification
REQ-031 Scenario: push 3 entries (addr 3/4/5), pulse cfg_start, waitrequest=0 → writes seen in order addr 0 (data 0), 3, 4, 5, 2 (data 1); done pulses once after pll_locked=1.
REQ-032 Scenario: waitrequest held high for 5 cycles on the entry-2 write → address and data stable for all 6 cycles; exactly one pop occurs.
REQ-033 Scenario: DEPTH=4, push 5 entries → ovf=1; only 4 entries are written; ovf clears on the next cfg_start.
REQ-034 Scenario: PLL_RECONF_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, pll_locked stuck at 0 → err pulses exactly 100 cycles after WAIT_LOCK entry; busy=0 on the next cycle.
REQ-035 Scenario: rst_n low during STREAM → mgmt_write=0 within the same cycle; after release, a cfg_start with no new pushes is ignored (FIFO empty).
REQ-036 Scenario: cfg_start and wr_en in the same IDLE cycle with the FIFO empty → that single entry is written between MODE and START.

Source files
------------

// File: rtl/pll_reconf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_reconf_pkg
// Brief    : Shared types and constants for the PLL reconfiguration sequencer:
//            FSM state enum, reconfig register addresses and the FIFO entry.
// Revision : 1.0 - initial release
// ============================================================================
package pll_reconf_pkg;

    // Reconfig register map used by the sequencer itself
    localparam logic [5:0] REG_MODE  = 6'd0;   // mode register: 0 selects waitrequest mode
    localparam logic [5:0] REG_START = 6'd2;   // writing 1 launches the reconfiguration

    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 32;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    // One queued register write: address in the upper bits, value in the lower
    typedef logic [ENTRY_W-1:0] entry_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MODE      = 3'd1,
        STREAM    = 3'd2,
        START     = 3'd3,
        SETTLE    = 3'd4,
        WAIT_LOCK = 3'd5,
        DONE      = 3'd6,
        ERR       = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pll_reconf_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pll_reconf_fifo
// Brief    : Entry FIFO for queued reconfig writes. Pointers carry one extra
//            wrap bit so full/empty are told apart by the MSBs. A pop is
//            ignored when empty and a push is ignored when full.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reconf_fifo
    import pll_reconf_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic               full,
    output logic               empty,
    output logic               single,
    output logic [ENTRY_W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]        w_level;
    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_level = wr_ptr_q - rd_ptr_q;
    // Exactly one entry left: the entry at the head is the final one
    assign single  = (w_level == (AW+1)'(1));
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    assign w_push  = push && !full;
    assign w_pop   = pop && !empty;

    // Next pointer values; the extra bit makes them wrap modulo 2*DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Pointer registers; reset empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset since the pointers gate validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pll_reconf_seq.sv
`default_nettype none
// ============================================================================
// Module   : pll_reconf_seq
// Brief    : PLL reconfiguration sequencer. Queues register writes, then on
//            cfg_start replays them over an Avalon-MM master bracketed by a
//            mode write and a start write, waits a settle time and then for
//            PLL lock.
// Config   : PLL_RECONF_TIMEOUT_EN - when defined, a lock watchdog aborts to
//            ERR after TIMEOUT_CYCLES in WAIT_LOCK; otherwise err is tied 0.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reconf_seq
    import pll_reconf_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int SETTLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [5:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        cfg_start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        ovf,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        mgmt_write,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] c_settle_last = SETTLE_W'(SETTLE_CYCLES - 1);

    // Reject unusable parameterisations at elaboration time
    if ((DEPTH < 4) || (DEPTH > 64) || ((DEPTH & (DEPTH - 1)) != 0) ||
        (SETTLE_CYCLES < 1) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("pll_reconf_seq: illegal parameter value");
    end

    logic               rst_int_n;
    logic [1:0]         rst_sync_q;

    state_t             state_q, state_d;
    logic [5:0]         cmd_addr_q, cmd_addr_d;
    logic [31:0]        cmd_data_q, cmd_data_d;
    logic               mgmt_write_q, mgmt_write_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;

    logic               w_fifo_push;
    logic               w_fifo_pop;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_fifo_single;
    logic [ENTRY_W-1:0] w_fifo_head;
    logic               w_start_ok;
    logic               w_accept;
    logic               w_drop;

`ifdef PLL_RECONF_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0]    wd_cnt_q, wd_cnt_d;
    logic               err_q, err_d;
`endif

    // Reset asserts immediately and releases two clocks after rst_n rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync_q[1];

    // Entries are only accepted while idle; a push while full is dropped
    assign w_fifo_push = wr_en && (state_q == IDLE);
    assign w_drop      = w_fifo_push && w_fifo_full;
    // A same-cycle push guarantees a non-empty FIFO, so it also qualifies
    assign w_start_ok  = (state_q == IDLE) && cfg_start && (!w_fifo_empty || wr_en);
    assign w_accept    = mgmt_write_q && !mgmt_waitrequest;

    pll_reconf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_int_n),
        .push      (w_fifo_push),
        .push_data ({wr_addr, wr_data}),
        .pop       (w_fifo_pop),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .single    (w_fifo_single),
        .head      (w_fifo_head)
    );

    // Next-state, next-output and counter logic for the sequencer
    always_comb begin
        state_d      = state_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_data_d   = cmd_data_q;
        mgmt_write_d = 1'b0;
        done_d       = 1'b0;
        ovf_d        = ovf_q;
        settle_cnt_d = settle_cnt_q;
        w_fifo_pop   = 1'b0;
`ifdef PLL_RECONF_TIMEOUT_EN
        wd_cnt_d     = wd_cnt_q;
        err_d        = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (w_start_ok) begin
                    state_d      = MODE;
                    cmd_addr_d   = REG_MODE;
                    cmd_data_d   = 32'd0;
                    mgmt_write_d = 1'b1;
                end
            end
            MODE: begin
                mgmt_write_d = 1'b1;
                if (w_accept) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // Address/data come straight from the FIFO head in this state
                mgmt_write_d = 1'b1;
                if (w_accept) begin
                    w_fifo_pop = 1'b1;
                    if (w_fifo_single) begin
                        state_d    = START;
                        cmd_addr_d = REG_START;
                        cmd_data_d = 32'd1;
                    end
                end
            end
            START: begin
                mgmt_write_d = 1'b1;
                if (w_accept) begin
                    state_d      = SETTLE;
                    mgmt_write_d = 1'b0;
                    settle_cnt_d = '0;
                end
            end
            SETTLE: begin
                if (settle_cnt_q == c_settle_last) begin
                    state_d = WAIT_LOCK;
`ifdef PLL_RECONF_TIMEOUT_EN
                    wd_cnt_d = '0;
`endif
                end else begin
                    settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (pll_locked) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
`ifdef PLL_RECONF_TIMEOUT_EN
                else if (wd_cnt_q == c_to_last) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + TO_W'(1);
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A drop in the same cycle as a start is still reported
        if (w_start_ok) begin
            ovf_d = 1'b0;
        end
        if (w_drop) begin
            ovf_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q      <= IDLE;
            cmd_addr_q   <= 6'd0;
            cmd_data_q   <= 32'd0;
            mgmt_write_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_data_q   <= cmd_data_d;
            mgmt_write_q <= mgmt_write_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

`ifdef PLL_RECONF_TIMEOUT_EN
    // Lock watchdog counter and error pulse
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy           = busy_q;
    assign done           = done_q;
    assign ovf            = ovf_q;
    assign mgmt_write     = mgmt_write_q;
    assign mgmt_address   = (state_q == STREAM) ? w_fifo_head[ENTRY_W-1:DATA_W] : cmd_addr_q;
    assign mgmt_writedata = (state_q == STREAM) ? w_fifo_head[DATA_W-1:0]       : cmd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_reconf_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_reconf_seq
// Brief    : Self-checking bench for pll_reconf_seq. A queue-based reference
//            model predicts busy/done/err/ovf and the expected Avalon write
//            stream; directed scenarios are followed by random traffic.
// Config   : PLL_RECONF_TIMEOUT_EN - also exercises the lock watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reconf_seq;

    localparam int DEPTH  = 4;
    localparam int SETTLE = 8;
    localparam int TMO    = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        cfg_start = 1'b0;
    logic        busy, done, err, ovf;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_write;
    logic        mgmt_waitrequest = 1'b0;
    logic        pll_locked = 1'b0;

    always #5 clk = ~clk;

    pll_reconf_seq #(
        .DEPTH          (DEPTH),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .cfg_start        (cfg_start),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .ovf              (ovf),
        .mgmt_address     (mgmt_address),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_write       (mgmt_write),
        .mgmt_waitrequest (mgmt_waitrequest),
        .pll_locked       (pll_locked)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_no = 0;

    // Reference model: queued entries, the write stream still owed, and the
    // remaining settle / lock-wait phase of a running sequence
    logic [37:0] m_fifo[$];
    logic [37:0] m_wr[$];
    bit          m_ovf, m_act, m_lockw;
    int          m_settle, m_wcnt, m_pulse;   // m_pulse: 0 none, 1 done, 2 err

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_no);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_wr.delete();
        m_ovf = 1'b0; m_act = 1'b0; m_lockw = 1'b0;
        m_settle = 0; m_wcnt = 0; m_pulse = 0;
    endtask

    task automatic model_step(input bit wr, input logic [5:0] a, input logic [31:0] d,
                              input bit st, input bit wq, input bit lk);
        bit push_ok, start_ok;
        if (!m_act) begin
            push_ok  = wr && (m_fifo.size() < DEPTH);
            start_ok = st && ((m_fifo.size() > 0) || push_ok);
            if (push_ok) m_fifo.push_back({a, d});
            if (start_ok) begin
                m_ovf = 1'b0;
                m_act = 1'b1;
                m_wr.delete();
                m_wr.push_back({6'd0, 32'd0});
                foreach (m_fifo[i]) m_wr.push_back(m_fifo[i]);
                m_wr.push_back({6'd2, 32'd1});
                m_fifo.delete();
            end
            if (wr && !push_ok) m_ovf = 1'b1;
        end else if (m_pulse != 0) begin
            m_act = 1'b0;
            m_pulse = 0;
        end else if (m_wr.size() > 0) begin
            if (!wq) begin
                void'(m_wr.pop_front());
                if (m_wr.size() == 0) m_settle = SETTLE;
            end
        end else if (m_settle > 0) begin
            m_settle--;
            if (m_settle == 0) begin
                m_lockw = 1'b1;
                m_wcnt = 0;
            end
        end else if (m_lockw) begin
            if (lk) begin
                m_lockw = 1'b0;
                m_pulse = 1;
            end
`ifdef PLL_RECONF_TIMEOUT_EN
            else if (m_wcnt == TMO - 1) begin
                m_lockw = 1'b0;
                m_pulse = 2;
            end else begin
                m_wcnt++;
            end
`endif
        end
    endtask

    task automatic check_outputs();
        bit wr_exp;
        wr_exp = m_act && (m_wr.size() > 0);
        chk("busy", busy, m_act);
        chk("done", done, m_pulse == 1);
        chk("err", err, m_pulse == 2);
        chk("ovf", ovf, m_ovf);
        chk("mgmt_write", mgmt_write, wr_exp);
        if (wr_exp) begin
            chk("mgmt_address", mgmt_address, m_wr[0][37:32]);
            chk("mgmt_writedata", mgmt_writedata, m_wr[0][31:0]);
        end
    endtask

    // Apply one cycle of inputs (from the falling edge), advance the model,
    // then check outputs on the next falling edge
    task automatic cyc(input bit wr, input logic [5:0] a, input logic [31:0] d,
                       input bit st, input bit wq, input bit lk);
        wr_en = wr; wr_addr = a; wr_data = d;
        cfg_start = st; mgmt_waitrequest = wq; pll_locked = lk;
        model_step(wr, a, d, st, wq, lk);
        @(posedge clk);
        @(negedge clk);
        cyc_no++;
        check_outputs();
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_to_idle(input string tag);
        for (int k = 0; k < 500 && m_act; k++) begin
            cyc(1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        end
        chk(tag, busy, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lw_start, err_seen;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_mgmt_write", mgmt_write, 1'b0);
        chk("rst_mgmt_address", mgmt_address, 6'd0);
        chk("rst_mgmt_writedata", mgmt_writedata, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        rst_n = 1'b1;
        repeat (3) idle_cyc();

        // Three entries, no backpressure, immediate lock
        for (int i = 0; i < 3; i++) cyc(1'b1, 6'(3 + i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        run_to_idle("seq3_end_busy");

        // Push and start in the same idle cycle with an empty FIFO
        cyc(1'b1, 6'd9, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        run_to_idle("same_cycle_end_busy");

        // Backpressure held on the second entry write
        for (int i = 0; i < 3; i++) cyc(1'b1, 6'(3 + i), 32'hB000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 20 && m_wr.size() > 3; k++) cyc(1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 6'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        run_to_idle("hold_end_busy");

        // Overflow: five pushes into a four-deep FIFO, cleared by the start
        for (int i = 0; i < 5; i++) cyc(1'b1, 6'(10 + i), 32'hC000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        run_to_idle("ovf_end_busy");

        // Random traffic, including ignored pushes/starts while busy
        for (int k = 0; k < 3000; k++) begin
            bit wr, st, wq, lk;
            wr = m_act ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
            st = m_act ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 5) == 0);
            wq = ($urandom_range(0, 2) == 0);
            lk = ($urandom_range(0, 5) == 0);
            cyc(wr, 6'($urandom), $urandom, st, wq, lk);
        end
        run_to_idle("random_end_busy");

        // Reset while streaming entries
        for (int i = 0; i < 3; i++) cyc(1'b1, 6'(20 + i), 32'hD000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("stream_before_rst", mgmt_write, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_mgmt_write", mgmt_write, 1'b0);
        chk("rst_async_busy", busy, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle_cyc();
        cyc(1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("start_after_rst_ignored", busy, 1'b0);
        idle_cyc();

`ifdef PLL_RECONF_TIMEOUT_EN
        // Lock never arrives: watchdog must fire after exactly TMO cycles
        lw_start = -1;
        err_seen = -1;
        cyc(1'b1, 6'd7, 32'hE000_0001, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 400 && m_act; k++) begin
            cyc(1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0);
            if (m_lockw && lw_start < 0) lw_start = cyc_no;
            if (err === 1'b1 && err_seen < 0) err_seen = cyc_no;
        end
        chk("tmo_gap", 64'(err_seen - lw_start), 64'(TMO));
        idle_cyc();
`else
        lw_start = 0;
        err_seen = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
